// File: rtl/clk_seq_ce_gen.sv
// clk_seq_ce_gen: PLL bring-up sequencer and multi-channel clock-enable generator.
// Drives the PLL RESET pin, filters the synchronised LOCK, holds the system reset
// until lock has been stable, then emits phase-aligned divided clock enables.
// Any loss of lock while running restarts the whole sequence.
// Optional feature: define CLKSEQ_TIMEOUT_EN to retry the PLL reset when lock does
// not arrive within TIMEOUT cycles.
module clk_seq_ce_gen #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 1,
    parameter int PLL_RST_CYC = 16,
    parameter int LOCK_FILT   = 256,
    parameter int TIMEOUT     = 4096
) (
    input  logic                      clkin,
    input  logic                      reset_n,
    input  logic                      pll_lock,
    output logic                      pll_reset,
    input  logic [CHANNELS*DIV_W-1:0] div_ratio,
    input  logic                      div_load,
    output logic [CHANNELS-1:0]       ce,
    output logic                      sys_rst_n,
    output logic                      locked,
    output logic [7:0]                relock_cnt
);

    typedef enum logic [1:0] {S_PLLRST, S_WAIT, S_FILT, S_RUN} state_t;

    localparam int RST_W  = $clog2(PLL_RST_CYC + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);
    // The S_WAIT cycle that first sees lock counts as the first filtered cycle,
    // so S_FILT itself only needs LOCK_FILT-1 further high cycles.
    localparam logic [FILT_W-1:0] FILT_LAST = (LOCK_FILT >= 2) ? FILT_W'(LOCK_FILT - 2) : '0;

    if (PLL_RST_CYC < 1 || LOCK_FILT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("clk_seq_ce_gen: PLL_RST_CYC, LOCK_FILT and TIMEOUT must be >= 1");
    end

    state_t              state, state_next;
    logic                lock_meta, lock_s;
    logic [RST_W-1:0]    rst_cnt;
    logic [FILT_W-1:0]   filt_cnt;
    logic                run_next;
    logic [DIV_W-1:0]    ratio     [CHANNELS];
    logic [DIV_W-1:0]    ratio_nxt [CHANNELS];
    logic [DIV_W-1:0]    cnt       [CHANNELS];
    logic [DIV_W-1:0]    cnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0] ce_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) state <= S_PLLRST;
        else          state <= state_next;
    end

`ifdef CLKSEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Wait-for-lock timer; cleared whenever S_WAIT is left.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) tmo_cnt <= '0;
        else          tmo_cnt <= (state == S_WAIT && state_next == S_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
    end
`endif

    // Next-state decisions, all taken on the synchronised lock.
    always_comb begin
        state_next = state;
        case (state)
            S_PLLRST: if (rst_cnt == RST_LAST) state_next = S_WAIT;
            S_WAIT: begin
                if (lock_s) state_next = (LOCK_FILT == 1) ? S_RUN : S_FILT;
`ifdef CLKSEQ_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) state_next = S_PLLRST;
`endif
            end
            S_FILT: begin
                if (!lock_s)                    state_next = S_WAIT;
                else if (filt_cnt == FILT_LAST) state_next = S_RUN;
            end
            S_RUN:   if (!lock_s) state_next = S_PLLRST;
            default: state_next = S_PLLRST;
        endcase
    end

    // Sequence outputs: PLL reset follows the state, run flag feeds the registered outputs.
    always_comb begin
        pll_reset = (state == S_PLLRST);
        run_next  = (state_next == S_RUN);
    end

    // Reset-hold and filter counters; each restarts from 0 on leaving its state.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt  <= '0;
            filt_cnt <= '0;
        end else begin
            rst_cnt  <= (state == S_PLLRST && state_next == S_PLLRST) ? rst_cnt + RST_W'(1) : '0;
            filt_cnt <= (state == S_FILT && state_next == S_FILT) ? filt_cnt + FILT_W'(1) : '0;
        end
    end

    // Registered system reset, lock flag and lock-loss counter.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            sys_rst_n <= run_next;
            locked    <= run_next;
            if (state == S_RUN && !lock_s) relock_cnt <= sat_inc(relock_cnt);
        end
    end

    // Divider next values: counters restart on run entry and on a ratio load.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            ratio_nxt[k] = div_load ? div_ratio[k*DIV_W +: DIV_W] : ratio[k];
            cnt_nxt[k]   = '0;
            if (state == S_RUN && run_next && !div_load && ratio[k] != '0 &&
                cnt[k] != ratio[k] - DIV_W'(1))
                cnt_nxt[k] = cnt[k] + DIV_W'(1);
            ce_nxt[k] = run_next && (ratio_nxt[k] != '0) && (cnt_nxt[k] == '0);
        end
    end

    // Ratio, divider counter and clock-enable registers.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                ratio[k] <= DIV_W'(DIV_DEFAULT);
                cnt[k]   <= '0;
            end
            ce <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                ratio[k] <= ratio_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            ce <= ce_nxt;
        end
    end

endmodule

// File: tb/tb_clk_seq_ce_gen.sv
// Bench for clk_seq_ce_gen: directed stimulus pushes expected values tagged with
// their cycle into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_clk_seq_ce_gen;

    localparam int F_PLLRST  = 0;
    localparam int F_SYSRST  = 1;
    localparam int F_LOCKED  = 2;
    localparam int F_CE      = 3;
    localparam int F_RELOCK  = 4;
    localparam int F_RELOCK2 = 5;
    localparam int F_LOCKED2 = 6;

`ifdef CLKSEQ_TIMEOUT_EN
    localparam logic TMO = 1'b1;
`else
    localparam logic TMO = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        int          fld;
        logic [7:0]  val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, pll_lock, div_load, pll_reset, sys_rst_n, locked;
    logic [31:0] div_ratio;
    logic [3:0]  ce;
    logic [7:0]  relock_cnt;

    logic        rst2_n, lock2, pr2, sr2, lk2, load2;
    logic [31:0] ratio2;
    logic [3:0]  ce2;
    logic [7:0]  rc2;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  mon_act;

    clk_seq_ce_gen dut (
        .clkin(clk), .reset_n(reset_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .div_ratio(div_ratio), .div_load(div_load), .ce(ce), .sys_rst_n(sys_rst_n),
        .locked(locked), .relock_cnt(relock_cnt)
    );

    clk_seq_ce_gen #(.PLL_RST_CYC(1), .LOCK_FILT(1), .TIMEOUT(8)) dut2 (
        .clkin(clk), .reset_n(rst2_n), .pll_lock(lock2), .pll_reset(pr2),
        .div_ratio(ratio2), .div_load(load2), .ce(ce2), .sys_rst_n(sr2),
        .locked(lk2), .relock_cnt(rc2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int unsigned c, int f, logic [7:0] v, string n);
        exp_t e;
        e.cyc = c; e.fld = f; e.val = v; e.name = n;
        sb.push_back(e);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.fld)
                F_PLLRST:  mon_act = {7'd0, pll_reset};
                F_SYSRST:  mon_act = {7'd0, sys_rst_n};
                F_LOCKED:  mon_act = {7'd0, locked};
                F_CE:      mon_act = {4'd0, ce};
                F_RELOCK:  mon_act = relock_cnt;
                F_RELOCK2: mon_act = rc2;
                F_LOCKED2: mon_act = {7'd0, lk2};
                default:   mon_act = 8'hxx;
            endcase
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d reached monitor late at cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s @cycle %0d: got 0x%02h, expected 0x%02h",
                         mon_e.name, cyc, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, r, r0, d, b;
        logic [7:0]  v;
        int          s, guard;

        reset_n = 1'b0; pll_lock = 1'b1; div_load = 1'b0; div_ratio = '0;
        rst2_n = 1'b0; lock2 = 1'b1; load2 = 1'b0; ratio2 = '0;

        // Reset values.
        tick(3);
        expect_at(cyc, F_PLLRST, 8'd1, "rst_pll_reset");
        expect_at(cyc, F_SYSRST, 8'd0, "rst_sys_rst_n");
        expect_at(cyc, F_LOCKED, 8'd0, "rst_locked");
        expect_at(cyc, F_CE,     8'd0, "rst_ce");
        expect_at(cyc, F_RELOCK, 8'd0, "rst_relock_cnt");
        tick(1);

        // Bring-up with lock tied high.
        reset_n = 1'b1;
        base = cyc;
        expect_at(base + 0,   F_PLLRST, 8'd1,  "bringup_pll_reset_c0");
        expect_at(base + 15,  F_PLLRST, 8'd1,  "bringup_pll_reset_c15");
        expect_at(base + 16,  F_PLLRST, 8'd0,  "bringup_pll_reset_c16");
        expect_at(base + 271, F_SYSRST, 8'd0,  "bringup_sys_rst_n_c271");
        expect_at(base + 271, F_CE,     8'd0,  "bringup_ce_c271");
        expect_at(base + 272, F_SYSRST, 8'd1,  "bringup_sys_rst_n_c272");
        expect_at(base + 272, F_LOCKED, 8'd1,  "bringup_locked_c272");
        expect_at(base + 272, F_CE,     8'h0F, "bringup_ce_c272");
        expect_at(base + 273, F_CE,     8'h0F, "bringup_ce_c273");
        tick(274);

        // Ratios {0,1,3,5} loaded in run: realign then 30 cycles of pattern.
        div_ratio = {8'd5, 8'd3, 8'd1, 8'd0};
        div_load  = 1'b1;
        r = cyc + 1;
        for (int t = 0; t < 30; t++) begin
            v = {4'd0, 1'(t % 5 == 0), 1'(t % 3 == 0), 1'b1, 1'b0};
            expect_at(r + t, F_CE, v, "ratio_pattern_ce");
        end
        tick(1);
        div_load = 1'b0;
        tick(30);

        // Realign again, then reload ch2 to 4 at run cycle 7.
        div_load = 1'b1;
        r0 = cyc + 1;
        tick(1);
        div_load = 1'b0;
        for (int t = 0; t < 21; t++) begin
            if (t < 8) v = {4'd0, 1'(t % 5 == 0), 1'(t % 3 == 0), 1'b1, 1'b0};
            else begin
                s = t - 8;
                v = {4'd0, 1'(s % 5 == 0), 1'(s % 4 == 0), 1'b1, 1'b0};
            end
            expect_at(r0 + t, F_CE, v, "reload_ce");
        end
        tick(7);
        div_ratio = {8'd5, 8'd4, 8'd1, 8'd0};
        div_load  = 1'b1;
        tick(1);
        div_load = 1'b0;
        tick(13);

        // Lock lost for 10 cycles in run, plus a 1-cycle glitch at filter count 200.
        d = cyc;
        expect_at(d + 2,   F_SYSRST, 8'd1,  "loss_sys_rst_n_d2");
        expect_at(d + 2,   F_RELOCK, 8'd0,  "loss_relock_d2");
        expect_at(d + 3,   F_SYSRST, 8'd0,  "loss_sys_rst_n_d3");
        expect_at(d + 3,   F_CE,     8'd0,  "loss_ce_d3");
        expect_at(d + 3,   F_LOCKED, 8'd0,  "loss_locked_d3");
        expect_at(d + 3,   F_RELOCK, 8'd1,  "loss_relock_d3");
        expect_at(d + 3,   F_PLLRST, 8'd1,  "loss_pll_reset_d3");
        expect_at(d + 18,  F_PLLRST, 8'd1,  "loss_pll_reset_d18");
        expect_at(d + 19,  F_PLLRST, 8'd0,  "loss_pll_reset_d19");
        expect_at(d + 275, F_SYSRST, 8'd0,  "glitch_no_early_run");
        expect_at(d + 478, F_SYSRST, 8'd0,  "glitch_sys_rst_n_d478");
        expect_at(d + 478, F_CE,     8'd0,  "glitch_ce_d478");
        expect_at(d + 479, F_SYSRST, 8'd1,  "glitch_sys_rst_n_d479");
        expect_at(d + 479, F_LOCKED, 8'd1,  "glitch_locked_d479");
        expect_at(d + 479, F_CE,     8'h0E, "glitch_ce_d479");
        expect_at(d + 479, F_RELOCK, 8'd1,  "glitch_relock_d479");
        pll_lock = 1'b0;
        tick(10);
        pll_lock = 1'b1;
        tick(210);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(259);

        // Asynchronous reset in the middle of a run cycle.
        expect_at(cyc, F_LOCKED, 8'd1, "pre_async_locked");
        expect_at(cyc, F_RELOCK, 8'd1, "pre_async_relock");
        tick(1);
        expect_at(cyc, F_PLLRST, 8'd1, "async_pll_reset");
        expect_at(cyc, F_SYSRST, 8'd0, "async_sys_rst_n");
        expect_at(cyc, F_LOCKED, 8'd0, "async_locked");
        expect_at(cyc, F_CE,     8'd0, "async_ce");
        expect_at(cyc, F_RELOCK, 8'd0, "async_relock");
        #1;
        reset_n = 1'b0;

        // Lock never arrives: timeout retry only when the feature is built.
        pll_lock = 1'b0;
        tick(2);
        reset_n = 1'b1;
        b = cyc;
        expect_at(b + 15,   F_PLLRST, 8'd1,       "nolock_pll_reset_c15");
        expect_at(b + 16,   F_PLLRST, 8'd0,       "nolock_pll_reset_c16");
        expect_at(b + 4111, F_PLLRST, 8'd0,       "nolock_pll_reset_c4111");
        expect_at(b + 4112, F_PLLRST, {7'd0, TMO}, "nolock_pll_reset_c4112");
        expect_at(b + 4127, F_PLLRST, {7'd0, TMO}, "nolock_pll_reset_c4127");
        expect_at(b + 4128, F_PLLRST, 8'd0,       "nolock_pll_reset_c4128");
        expect_at(b + 8223, F_PLLRST, 8'd0,       "nolock_pll_reset_c8223");
        expect_at(b + 8224, F_PLLRST, {7'd0, TMO}, "nolock_pll_reset_c8224");
        expect_at(b + 8225, F_RELOCK, 8'd0,       "nolock_relock");
        tick(8226);

        // Saturation of the lock-loss counter on a fast-sequencing instance.
        rst2_n = 1'b1;
        tick(10);
        expect_at(cyc, F_LOCKED2, 8'd1, "sat_locked_start");
        expect_at(cyc, F_RELOCK2, 8'd0, "sat_relock_start");
        for (int i = 0; i < 300; i++) begin
            lock2 = 1'b0;
            tick(1);
            lock2 = 1'b1;
            tick(4);
            if (i == 9)   expect_at(cyc, F_RELOCK2, 8'd10,  "sat_relock_10");
            if (i == 253) expect_at(cyc, F_RELOCK2, 8'd254, "sat_relock_254");
            if (i == 254) expect_at(cyc, F_RELOCK2, 8'd255, "sat_relock_255");
        end
        expect_at(cyc, F_RELOCK2, 8'd255, "sat_relock_300");
        expect_at(cyc, F_LOCKED2, 8'd1,   "sat_locked_end");
        tick(2);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
            errors += sb.size();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
